// File: rtl/fetch_sequencer_if.sv
// Harness/decoder-facing bundle for the fetch sequencer.
// Master drives program load, run control and decoder feedback.
interface fetch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int DW    = 8,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Done;
  logic             Run;
  logic             prog_we;
  logic [PC_W-1:0]  prog_addr;
  logic [8:0]       prog_data;
  logic [PC_W-1:0]  prog_last;
  logic [8:0]       Instr;
  logic [PC_W-1:0]  PC;
  logic             Branch;
  logic             Jump;
  logic             Zero;
  logic [DW-1:0]    jump_target;
  logic [CNT_W-1:0] InstCount;

  modport master (
    output Start, prog_we, prog_addr, prog_data,
    output prog_last, Branch, Jump, Zero, jump_target,
    input  Done, Run, Instr, PC, InstCount
  );

  modport slave (
    input  Start, prog_we, prog_addr, prog_data,
    input  prog_last, Branch, Jump, Zero, jump_target,
    output Done, Run, Instr, PC, InstCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program memory, PC and run control for the single-cycle core.
// Zero-latency fetch: Instr is mem[PC] combinationally while running.
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input logic             Clk,
  input logic             Reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       mem_q [0:(1<<PC_W)-1];

  logic [PC_W-1:0]  jt_ext;
  logic [PC_W-1:0]  boff;
  logic [8:0]       instr;
  logic             run;

  generate
    if (DW >= PC_W) begin : g_jt_trunc
      assign jt_ext = bus.jump_target[PC_W-1:0];
    end else begin : g_jt_zext
      assign jt_ext = {{(PC_W-DW){1'b0}}, bus.jump_target};
    end
  endgenerate

  assign run   = (state_q == S_RUN);
  assign instr = run ? mem_q[pc_q] : 9'h000;
  assign boff  = {{(PC_W-5){instr[4]}}, instr[4:0]};

  assign bus.Run       = run;
  assign bus.Done      = (state_q == S_DONE);
  assign bus.Instr     = instr;
  assign bus.PC        = pc_q;
  assign bus.InstCount = cnt_q;

  // Memory survives Reset; loads are locked out only while running.
  always_ff @(posedge Clk) begin
    if (bus.prog_we && state_q != S_RUN)
      mem_q[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        if (bus.Jump) begin
          pc_d = jt_ext;
        end else if (bus.Branch && bus.Zero) begin
          pc_d = pc_q + boff;
        end else if (pc_q == bus.prog_last) begin
          state_d = S_DONE;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      default: begin
        if (bus.Start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic
// against an abstract run/PC/memory reference model.
module tb_fetch_sequencer;

  localparam int PC_W  = 10;
  localparam int DW    = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << PC_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Reset;

  fetch_sequencer_if #(.PC_W(PC_W), .DW(DW), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .DW(DW), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // stimulus variables
  logic       s_rst, s_start, s_we, s_br, s_jmp, s_z;
  logic [9:0] s_addr, s_last;
  logic [8:0] s_data;
  logic [7:0] s_jt;

  // reference model
  bit         m_run, m_done;
  int         m_pc, m_cnt;
  logic [8:0] m_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    s_rst = 0; s_start = 0; s_we = 0; s_br = 0;
    s_jmp = 0; s_z = 0; s_addr = '0; s_data = '0; s_jt = '0;
  endtask

  function automatic int br_off(input logic [8:0] w);
    int v;
    v = int'(w[4:0]);
    if (w[4]) v = v - 32;
    return v;
  endfunction

  task automatic model_step();
    if (s_we && !m_run) m_mem[s_addr] = s_data;
    if (s_rst) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    end else if (m_run) begin
      if (m_cnt < CMAX) m_cnt++;
      if (s_jmp)
        m_pc = int'(s_jt) % DEPTH;
      else if (s_br && s_z)
        m_pc = (m_pc + br_off(m_mem[m_pc]) + DEPTH) % DEPTH;
      else if (m_pc == int'(s_last)) begin
        m_run = 0; m_done = 1;
      end else
        m_pc = (m_pc + 1) % DEPTH;
    end else if (s_start) begin
      m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
    end
  endtask

  task automatic cyc();
    logic [8:0] ei;
    Reset           = s_rst;
    bus.Start       = s_start;
    bus.prog_we     = s_we;
    bus.prog_addr   = s_addr;
    bus.prog_data   = s_data;
    bus.prog_last   = s_last;
    bus.Branch      = s_br;
    bus.Jump        = s_jmp;
    bus.Zero        = s_z;
    bus.jump_target = s_jt;
    @(negedge Clk);
    ei = m_run ? m_mem[m_pc] : 9'h000;
    chk("run",   32'(bus.Run),       32'(m_run));
    chk("done",  32'(bus.Done),      32'(m_done));
    chk("pc",    32'(bus.PC),        32'(m_pc));
    chk("instr", 32'(bus.Instr),     32'(ei));
    chk("cnt",   32'(bus.InstCount), 32'(m_cnt));
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int a, input logic [8:0] d);
    clr(); s_we = 1; s_addr = 10'(a); s_data = d; cyc(); clr();
  endtask

  task automatic jump_to(input int t);
    clr(); s_jmp = 1; s_jt = 8'(t); cyc(); clr();
  endtask

  initial begin
    clr();
    s_last = 10'd3;
    m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    s_rst = 1;
    cyc();
    cyc();
    chk("rst_run", 32'(bus.Run), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_pc", 32'(bus.PC), 0);
    chk("rst_cnt", 32'(bus.InstCount), 0);
    chk("rst_instr", 32'(bus.Instr), 0);
    clr();

    for (int i = 0; i < DEPTH; i++) load(i, 9'($urandom));

    // basic run of four words
    load(0, 9'h040); load(1, 9'h081);
    load(2, 9'h0C2); load(3, 9'h103);
    s_start = 1; cyc(); clr();
    chk("b_instr0", 32'(bus.Instr), 32'h040);
    for (int i = 0; i < 4; i++) cyc();
    chk("b_done", 32'(bus.Done), 1);
    chk("b_run", 32'(bus.Run), 0);
    chk("b_cnt", 32'(bus.InstCount), 4);
    chk("b_pc", 32'(bus.PC), 3);

    // branches and jump priority
    load(5, 9'h01D);
    load(0, 9'h01F);
    load(2, 9'h01C);
    s_start = 1; cyc(); clr();
    jump_to(5);
    s_br = 1; s_z = 1; cyc(); clr();
    chk("br_taken", 32'(bus.PC), 2);
    jump_to(5);
    s_br = 1; s_z = 0; cyc(); clr();
    chk("br_not", 32'(bus.PC), 6);
    jump_to(7);
    s_jmp = 1; s_br = 1; s_z = 1; s_jt = 8'hC8; cyc(); clr();
    chk("jmp_prio", 32'(bus.PC), 200);

    // wrap both ways
    jump_to(0);
    s_br = 1; s_z = 1; cyc(); clr();
    chk("wrap_neg", 32'(bus.PC), 1023);
    cyc();
    chk("wrap_pos", 32'(bus.PC), 0);
    cyc(); cyc();
    s_br = 1; s_z = 1; cyc(); clr();
    chk("br_m4", 32'(bus.PC), 1022);

    // write during run is dropped
    s_we = 1; s_addr = '0; s_data = 9'h1AB; cyc(); clr();
    jump_to(0);
    chk("run_wr", 32'(bus.Instr), 32'h01F);
    jump_to(3);
    cyc();
    chk("d_done", 32'(bus.Done), 1);
    load(0, 9'h1AB);
    s_start = 1; cyc(); clr();
    chk("done_wr", 32'(bus.Instr), 32'h1AB);

    // reset mid-run
    cyc(); cyc(); cyc();
    chk("pre_rst_pc", 32'(bus.PC), 3);
    s_rst = 1; cyc(); clr();
    chk("mr_run", 32'(bus.Run), 0);
    chk("mr_pc", 32'(bus.PC), 0);
    chk("mr_cnt", 32'(bus.InstCount), 0);
    chk("mr_instr", 32'(bus.Instr), 0);
    s_start = 1; cyc(); clr();
    chk("mem_kept", 32'(bus.Instr), 32'h1AB);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      s_rst   = ($urandom % 64) == 0;
      s_start = ($urandom % 6) == 0;
      s_we    = ($urandom % 4) == 0;
      s_addr  = 10'($urandom % 64);
      s_data  = 9'($urandom);
      s_jmp   = ($urandom % 8) == 0;
      s_br    = ($urandom % 4) == 0;
      s_z     = 1'($urandom);
      s_jt    = 8'($urandom % 80);
      if (!m_run) s_last = 10'($urandom % 48);
      cyc();
    end
    clr();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side counterpart to the control decoder: holds program memory and the program counter, and issues one 9-bit instruction per cycle.
- Consumes the decoder's Branch and Jump outputs, the ALU Zero flag and the ALU jump target to compute the next PC.
- Provides a program-load port and a Start/Done handshake for the top-level test harness.
- Sits between the harness and the control decoder / datapath of the single-cycle core.

Parameters:
- PC_W, 10, program counter and program memory address width; memory depth 2**PC_W words of 9 bits
- DW, 8, datapath width of jump_target
- CNT_W, 16, width of the executed-instruction counter

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  level; begins a run from address 0 when sampled high in IDLE or DONE
- Done  output  1  high while in DONE
- Run  output  1  high while in RUN; qualifies Instr (downstream gates RegWrite/MemWrite with Run)
- prog_we  input  1  program memory write enable; honoured only in IDLE/DONE
- prog_addr  input  PC_W  program memory write address
- prog_data  input  9  program memory write data
- prog_last  input  PC_W  address of final instruction; stable during a run
- Instr  output  9  instruction at PC; forced to 9'h000 when Run=0
- PC  output  PC_W  current program counter
- Branch  input  1  from control decoder
- Jump  input  1  from control decoder
- Zero  input  1  ALU result-zero flag, same cycle
- jump_target  input  DW  ALU output (rd1 pass-through) for JAL
- InstCount  output  CNT_W  instructions executed in current/last run

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE, PC=0, InstCount=0, Done=0, Run=0.
- Reset does not clear program memory; Reset mid-RUN aborts the run and returns to IDLE on that edge.
- Program memory: write synchronous on Clk when prog_we=1 and state != RUN; writes in RUN are ignored. Read is asynchronous, so Instr = mem[PC] in the same cycle (zero-latency fetch) whenever Run=1.
- IDLE/DONE with Start=1: next state RUN, PC<=0, InstCount<=0, Done<=0. A simultaneous prog_we on the same edge is still honoured (state is not yet RUN).
- RUN, every cycle: InstCount <= InstCount+1, saturating at all-ones. Next PC is selected with this priority:
  - Jump=1: PC <= zero-extended jump_target (truncated if DW > PC_W).
  - Branch=1 and Zero=1: PC <= PC + sign-extend(Instr[4:0]); range -16..+15, modulo 2**PC_W (wrap-around).
  - Otherwise: PC <= PC+1, modulo 2**PC_W.
- Branch=1 with Zero=0 is not taken and falls through to PC+1.
- Termination: in RUN, if PC==prog_last and neither a jump nor a taken branch occurs, next state is DONE. PC holds prog_last, and InstCount includes that final instruction. A taken jump/branch at prog_last continues the run.
- Start is ignored in RUN. DONE holds until Start=1; Start held high in DONE restarts immediately.
- Offset 0 on a taken branch loops on the same PC (legal, no protection).
- Done and Run are registered state decodes and are never simultaneously high.

Test Plan:
- Reset, load 4 non-branch words at 0..3, prog_last=3, pulse Start -> Run high 4 cycles, PC 0,1,2,3, Instr matches memory each cycle, then Done=1, InstCount=4, PC=3.
- At PC=5 drive Branch=1, Zero=1, Instr[4:0]=5'b11101 -> next PC=2; repeat with Zero=0 -> next PC=6.
- At PC=7 drive Jump=1, Branch=1, Zero=1, jump_target=8'hC8 -> next PC=200 (Jump priority).
- PC_W=10 with PC=1023 and a non-branch instruction -> PC wraps to 0; at PC=2, branch offset -4 -> PC=1022.
- prog_we to address 0 with data 9'h1AB during RUN -> memory unchanged; same write in DONE -> read back 9'h1AB on the next run.
- Assert Reset at PC=3 mid-run -> IDLE next edge, PC=0, InstCount=0, Run=0, Instr=9'h000; program memory contents intact on re-Start.
